otl_cfg_arb: RTL and testbench
==============================

Name: otl_cfg_arb

Overview:
- Two-requester arbiter that shares one otl_cfg_mem instance between requester 0 (host bus bridge) and requester 1 (local engine).
- Round-robin arbitration per port: one arbiter for the write port, one for the read port.
- Read path: one outstanding read, response routed back to the owning requester, timeout protection, read-after-write hazard stall.
- Sits directly between the requesters and otl_cfg_mem's wr*/rd* ports.

Parameters:
- DATAW, 32, data width; matches the memory.
- ADDRW, 4, address width; matches the memory.
- TMOW, 4, width of the read-timeout counter.
- TMO_CYCLES, 15, cycles in RD_WAIT before a timeout response; must be ≤ 2^TMOW-1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- mN_wr_addr  in  ADDRW  write address (N = 0, 1).
- mN_wr_data  in  DATAW  write data.
- mN_wr_valid  in  1  write request.
- mN_wr_ready  out  1  write accepted this cycle.
- mN_rd_addr  in  ADDRW  read address.
- mN_rd_valid  in  1  read request.
- mN_rd_ready  out  1  read request accepted this cycle.
- mN_rsp_data  out  DATAW  read response data.
- mN_rsp_valid  out  1  one-cycle response strobe.
- mN_rsp_err  out  1  response is a timeout (qualified by rsp_valid).
- mem_wraddr  out  ADDRW  to memory wraddr.
- mem_wrdata  out  DATAW  to memory wrdata.
- mem_wrvalid  out  1  to memory wrvalid.
- mem_wrready  in  1  from memory wrready.
- mem_rdaddr  out  ADDRW  to memory rdaddr.
- mem_rdready  out  1  to memory rdready (read strobe).
- mem_rddata  in  DATAW  from memory rddata.
- mem_rdvalid  in  1  from memory rdvalid.

Behaviour:
- Single clock domain, clk. reset is synchronous and active-high.
- Reset values:
  - all mN_* outputs 0; mem_rdready 0.
  - both round-robin pointers favour requester 0.
  - read FSM in RD_IDLE; timeout counter 0.
- Write arbiter (combinational grant, registered pointer):
  - mem_wrvalid = m0_wr_valid | m1_wr_valid.
  - Grant goes to the sole requester, or to the pointer-favoured requester on a tie.
  - mem_wraddr/mem_wrdata are muxed from the granted requester.
  - mN_wr_ready = grantN & mem_wrready.
  - On a handshake the pointer moves to favour the other requester. A lone requester may win every cycle (one write per cycle).
  - A losing requester must hold valid/addr/data stable until ready.
- Read FSM states:
  - RD_IDLE:
    - Pick a requester with the read round-robin rule (independent pointer).
    - Hazard stall: if mem_wrvalid and mem_wraddr == selected rd_addr this cycle, issue nothing.
    - Otherwise drive mem_rdready=1, mem_rdaddr=selected addr and mN_rd_ready=1 (combinational, same cycle).
    - Register the owner, clear the counter, update the pointer, go to RD_WAIT.
  - RD_WAIT:
    - mem_rdready=0; rd_ready=0 for both requesters; counter increments.
    - On mem_rdvalid=1: register mem_rddata into owner's rsp_data, pulse owner's rsp_valid next cycle with rsp_err=0, go to RD_IDLE.
    - Else if counter == TMO_CYCLES-1: owner gets rsp_valid next cycle with rsp_data=0 and rsp_err=1, go to RD_IDLE.
- Latency: accept at cycle T, mem_rdvalid at T+1, rsp_valid at T+2.
  - The FSM is in RD_IDLE at T+2 and may accept the next read then. Max throughput is one read per 2 cycles.
- rsp_valid and rsp_err are single-cycle pulses.
  - The non-owner's rsp_valid stays 0.
  - rsp_data holds its last value until the next response to that requester.
- mem_rdvalid arriving in RD_IDLE (late or spurious) is ignored.
- Reset mid-read: the outstanding read is dropped, no response is produced, and a pending rsp_valid is cleared.
- Write and read ports are independent: a write and a read to different addresses may both issue in the same cycle.

Test Plan:
- Reset, then m0 writes addr 3 = 0xDEADBEEF; m0 reads addr 3 -> m0_rd_ready at T, mem_rdready at T, m0_rsp_valid at T+2 with 0xDEADBEEF, rsp_err=0; m1_rsp_valid stays 0.
- m0 and m1 both hold wr_valid for 4 cycles (addrs 1, 2) -> grants alternate m0, m1, m0, m1; memory holds the last written data; after reset the first grant goes to m0.
- m1 writes addr 5 = 0x1234 while m0 requests a read of addr 5 in the same cycle -> read stalls one cycle, then m0_rsp_data = 0x1234.
- Memory model never asserts mem_rdvalid; m1 reads addr 7 -> m1_rsp_valid exactly TMO_CYCLES+1 cycles after accept, rsp_data=0, rsp_err=1; the FSM then accepts a new read.
- Both requesters hold rd_valid continuously -> accepts alternate m0, m1 every 2 cycles; each response goes only to its owner with the correct data.
- Assert reset the cycle after a read is accepted -> no rsp_valid for that read, outputs 0, next read after reset completes normally.

Source files
------------

// File: rtl/otl_cfg_arb.sv
// otl_cfg_arb: shares one otl_cfg_mem between the host bus bridge (requester 0)
// and the local engine (requester 1). The write port and the read port each
// have their own round-robin arbiter. The read side keeps one read
// outstanding, routes the response to its owner and gives up after a timeout.
module otl_cfg_arb #(
  parameter int DATAW      = 32,
  parameter int ADDRW      = 4,
  parameter int TMOW       = 4,
  parameter int TMO_CYCLES = 15
) (
  input  logic             clk,
  input  logic             reset,
  // requester 0 (host bus bridge)
  input  logic [ADDRW-1:0] m0_wr_addr,
  input  logic [DATAW-1:0] m0_wr_data,
  input  logic             m0_wr_valid,
  output logic             m0_wr_ready,
  input  logic [ADDRW-1:0] m0_rd_addr,
  input  logic             m0_rd_valid,
  output logic             m0_rd_ready,
  output logic [DATAW-1:0] m0_rsp_data,
  output logic             m0_rsp_valid,
  output logic             m0_rsp_err,
  // requester 1 (local engine)
  input  logic [ADDRW-1:0] m1_wr_addr,
  input  logic [DATAW-1:0] m1_wr_data,
  input  logic             m1_wr_valid,
  output logic             m1_wr_ready,
  input  logic [ADDRW-1:0] m1_rd_addr,
  input  logic             m1_rd_valid,
  output logic             m1_rd_ready,
  output logic [DATAW-1:0] m1_rsp_data,
  output logic             m1_rsp_valid,
  output logic             m1_rsp_err,
  // memory side
  output logic [ADDRW-1:0] mem_wraddr,
  output logic [DATAW-1:0] mem_wrdata,
  output logic             mem_wrvalid,
  input  logic             mem_wrready,
  output logic [ADDRW-1:0] mem_rdaddr,
  output logic             mem_rdready,
  input  logic [DATAW-1:0] mem_rddata,
  input  logic             mem_rdvalid
);

  typedef enum logic {
    RD_IDLE,
    RD_WAIT
  } rdState_e;

  localparam logic [TMOW-1:0] TMO_LAST = TMOW'(TMO_CYCLES - 1);

  rdState_e         rdState_q, rdState_d;
  logic             wrPtr_q, wrPtr_d;
  logic             rdPtr_q, rdPtr_d;
  logic             rdOwner_q, rdOwner_d;
  logic [TMOW-1:0]  tmoCnt_q, tmoCnt_d;
  logic [DATAW-1:0] rspData0_q, rspData0_d;
  logic [DATAW-1:0] rspData1_q, rspData1_d;
  logic             rspValid0_q, rspValid0_d;
  logic             rspValid1_q, rspValid1_d;
  logic             rspErr0_q, rspErr0_d;
  logic             rspErr1_q, rspErr1_d;

  logic             wrAny;
  logic             wrGrant0;
  logic             wrGrant1;
  logic             wrHandshake;
  logic             rdAny;
  logic             rdSel1;
  logic [ADDRW-1:0] rdSelAddr;
  logic             rdHazard;
  logic             rdIssue;
  logic             rdDone;
  logic [DATAW-1:0] rdRspData;
  logic             rdRspErr;

  // Write arbiter: a lone requester always wins, a tie goes to the favoured
  // requester, and a completed handshake hands the favour to the other side.
  always_comb begin
    wrAny       = m0_wr_valid | m1_wr_valid;
    wrGrant1    = m1_wr_valid & (~m0_wr_valid | wrPtr_q);
    wrGrant0    = m0_wr_valid & ~wrGrant1;
    wrHandshake = wrAny & mem_wrready & ~reset;
    mem_wrvalid = wrAny;
    mem_wraddr  = wrGrant1 ? m1_wr_addr : m0_wr_addr;
    mem_wrdata  = wrGrant1 ? m1_wr_data : m0_wr_data;
    m0_wr_ready = wrGrant0 & mem_wrready & ~reset;
    m1_wr_ready = wrGrant1 & mem_wrready & ~reset;
    wrPtr_d     = wrPtr_q;
    if (wrHandshake) begin
      wrPtr_d = wrGrant0;
    end
  end

  // Read FSM: pick a requester, hold off while a write hits the same address,
  // then wait for the memory or the timeout and route the result to the owner.
  always_comb begin
    rdAny       = m0_rd_valid | m1_rd_valid;
    rdSel1      = m1_rd_valid & (~m0_rd_valid | rdPtr_q);
    rdSelAddr   = rdSel1 ? m1_rd_addr : m0_rd_addr;
    rdHazard    = wrAny & (mem_wraddr == rdSelAddr);
    rdIssue     = (rdState_q == RD_IDLE) & rdAny & ~rdHazard & ~reset;
    mem_rdready = rdIssue;
    mem_rdaddr  = rdSelAddr;
    m0_rd_ready = rdIssue & ~rdSel1;
    m1_rd_ready = rdIssue & rdSel1;

    rdDone    = mem_rdvalid | (tmoCnt_q == TMO_LAST);
    rdRspData = mem_rdvalid ? mem_rddata : '0;
    rdRspErr  = ~mem_rdvalid;

    rdState_d   = rdState_q;
    rdPtr_d     = rdPtr_q;
    rdOwner_d   = rdOwner_q;
    tmoCnt_d    = tmoCnt_q;
    rspData0_d  = rspData0_q;
    rspData1_d  = rspData1_q;
    rspValid0_d = 1'b0;
    rspValid1_d = 1'b0;
    rspErr0_d   = 1'b0;
    rspErr1_d   = 1'b0;

    case (rdState_q)
      RD_IDLE: begin
        if (rdIssue) begin
          rdOwner_d = rdSel1;
          tmoCnt_d  = '0;
          rdPtr_d   = ~rdSel1;
          rdState_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        tmoCnt_d = tmoCnt_q + TMOW'(1);
        if (rdDone) begin
          rdState_d = RD_IDLE;
          if (rdOwner_q) begin
            rspData1_d  = rdRspData;
            rspValid1_d = 1'b1;
            rspErr1_d   = rdRspErr;
          end else begin
            rspData0_d  = rdRspData;
            rspValid0_d = 1'b1;
            rspErr0_d   = rdRspErr;
          end
        end
      end
      default: begin
        rdState_d = RD_IDLE;
      end
    endcase
  end

  // State registers; reset drops any outstanding read and pending response.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdState_q   <= RD_IDLE;
      wrPtr_q     <= 1'b0;
      rdPtr_q     <= 1'b0;
      rdOwner_q   <= 1'b0;
      tmoCnt_q    <= '0;
      rspData0_q  <= '0;
      rspData1_q  <= '0;
      rspValid0_q <= 1'b0;
      rspValid1_q <= 1'b0;
      rspErr0_q   <= 1'b0;
      rspErr1_q   <= 1'b0;
    end else begin
      rdState_q   <= rdState_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      rdOwner_q   <= rdOwner_d;
      tmoCnt_q    <= tmoCnt_d;
      rspData0_q  <= rspData0_d;
      rspData1_q  <= rspData1_d;
      rspValid0_q <= rspValid0_d;
      rspValid1_q <= rspValid1_d;
      rspErr0_q   <= rspErr0_d;
      rspErr1_q   <= rspErr1_d;
    end
  end

  assign m0_rsp_data  = rspData0_q;
  assign m0_rsp_valid = rspValid0_q;
  assign m0_rsp_err   = rspErr0_q;
  assign m1_rsp_data  = rspData1_q;
  assign m1_rsp_valid = rspValid1_q;
  assign m1_rsp_err   = rspErr1_q;

endmodule

// File: tb/tb_otl_cfg_arb.sv
// tb_otl_cfg_arb: directed scenarios followed by random traffic, every cycle
// checked against a transaction-level model of the arbiter.
module tb_otl_cfg_arb;

  localparam int DATAW      = 32;
  localparam int ADDRW      = 4;
  localparam int TMOW       = 4;
  localparam int TMO_CYCLES = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic [ADDRW-1:0] m0_wr_addr, m1_wr_addr, m0_rd_addr, m1_rd_addr;
  logic [DATAW-1:0] m0_wr_data, m1_wr_data;
  logic             m0_wr_valid, m1_wr_valid, m0_rd_valid, m1_rd_valid;
  logic             m0_wr_ready, m1_wr_ready, m0_rd_ready, m1_rd_ready;
  logic [DATAW-1:0] m0_rsp_data, m1_rsp_data;
  logic             m0_rsp_valid, m1_rsp_valid, m0_rsp_err, m1_rsp_err;
  logic [ADDRW-1:0] mem_wraddr, mem_rdaddr;
  logic [DATAW-1:0] mem_wrdata, mem_rddata;
  logic             mem_wrvalid, mem_wrready, mem_rdready, mem_rdvalid;

  otl_cfg_arb #(
    .DATAW(DATAW), .ADDRW(ADDRW), .TMOW(TMOW), .TMO_CYCLES(TMO_CYCLES)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_wr_addr(m0_wr_addr), .m0_wr_data(m0_wr_data), .m0_wr_valid(m0_wr_valid),
    .m0_wr_ready(m0_wr_ready), .m0_rd_addr(m0_rd_addr), .m0_rd_valid(m0_rd_valid),
    .m0_rd_ready(m0_rd_ready), .m0_rsp_data(m0_rsp_data), .m0_rsp_valid(m0_rsp_valid),
    .m0_rsp_err(m0_rsp_err),
    .m1_wr_addr(m1_wr_addr), .m1_wr_data(m1_wr_data), .m1_wr_valid(m1_wr_valid),
    .m1_wr_ready(m1_wr_ready), .m1_rd_addr(m1_rd_addr), .m1_rd_valid(m1_rd_valid),
    .m1_rd_ready(m1_rd_ready), .m1_rsp_data(m1_rsp_data), .m1_rsp_valid(m1_rsp_valid),
    .m1_rsp_err(m1_rsp_err),
    .mem_wraddr(mem_wraddr), .mem_wrdata(mem_wrdata), .mem_wrvalid(mem_wrvalid),
    .mem_wrready(mem_wrready), .mem_rdaddr(mem_rdaddr), .mem_rdready(mem_rdready),
    .mem_rddata(mem_rddata), .mem_rdvalid(mem_rdvalid)
  );

  always #5 clk = ~clk;

  // Memory stand-in: one-cycle read latency, optionally silent, plus an
  // injectable stray rdvalid for the idle-ignore case.
  logic [DATAW-1:0] memArray [16];
  logic             memSilent = 1'b0;
  logic             spurious = 1'b0;
  logic             memRdValid_q = 1'b0;
  logic [DATAW-1:0] memRdData_q = '0;
  assign mem_rdvalid = memRdValid_q | spurious;
  assign mem_rddata  = memRdData_q;

  // Memory write and read-response behaviour.
  always @(posedge clk) begin
    if (mem_wrvalid && mem_wrready) memArray[mem_wraddr] <= mem_wrdata;
    memRdValid_q <= mem_rdready && !memSilent;
    memRdData_q  <= memArray[mem_rdaddr];
  end

  int total = 0;
  int bad = 0;

  // Reference model state: favoured requesters, one outstanding read with the
  // cycle its answer is due, and a shadow of memory contents.
  int               cyc = 0;
  int               wrFav = 0;
  int               rdFav = 0;
  bit               busy = 0;
  int               owner = 0;
  int               respAt = 0;
  logic [DATAW-1:0] pendData = '0;
  bit               pendErr = 0;
  logic [DATAW-1:0] lastData [2];
  logic [DATAW-1:0] shadow [16];
  bit               accW0, accW1, accR0, accR1;

  task automatic check(input string tag, input logic [DATAW-1:0] obs, input logic [DATAW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst,
                               input bit w0v, input logic [ADDRW-1:0] w0a, input logic [DATAW-1:0] w0d,
                               input bit w1v, input logic [ADDRW-1:0] w1a, input logic [DATAW-1:0] w1d,
                               input bit r0v, input logic [ADDRW-1:0] r0a,
                               input bit r1v, input logic [ADDRW-1:0] r1a);
    reset       = rst;
    m0_wr_valid = w0v && !rst;
    m0_wr_addr  = w0a;
    m0_wr_data  = w0d;
    m1_wr_valid = w1v && !rst;
    m1_wr_addr  = w1a;
    m1_wr_data  = w1d;
    m0_rd_valid = r0v && !rst;
    m0_rd_addr  = r0a;
    m1_rd_valid = r1v && !rst;
    m1_rd_addr  = r1a;
  endtask

  task automatic checkOutput();
    bit expV [2];
    bit expE [2];
    int win, sel;
    bit wrAny, hs, rdAny, hazard, issue;
    logic [ADDRW-1:0] wa, ra;
    logic [DATAW-1:0] wd;
    if (reset) begin
      wrFav = 0;
      rdFav = 0;
      busy = 0;
      lastData[0] = '0;
      lastData[1] = '0;
      {accW0, accW1, accR0, accR1} = 4'b1111;
      return;
    end
    expV[0] = 0; expV[1] = 0; expE[0] = 0; expE[1] = 0;
    if (busy && cyc == respAt) begin
      expV[owner] = 1;
      expE[owner] = pendErr;
      lastData[owner] = pendData;
      busy = 0;
    end
    check("m0_rsp_valid", m0_rsp_valid, expV[0]);
    check("m1_rsp_valid", m1_rsp_valid, expV[1]);
    check("m0_rsp_err", m0_rsp_err, expE[0]);
    check("m1_rsp_err", m1_rsp_err, expE[1]);
    check("m0_rsp_data", m0_rsp_data, lastData[0]);
    check("m1_rsp_data", m1_rsp_data, lastData[1]);

    wrAny = m0_wr_valid || m1_wr_valid;
    win = (m0_wr_valid && m1_wr_valid) ? wrFav : (m1_wr_valid ? 1 : 0);
    wa = (win == 1) ? m1_wr_addr : m0_wr_addr;
    wd = (win == 1) ? m1_wr_data : m0_wr_data;
    hs = wrAny && mem_wrready;
    check("mem_wrvalid", mem_wrvalid, wrAny);
    if (wrAny) begin
      check("mem_wraddr", mem_wraddr, wa);
      check("mem_wrdata", mem_wrdata, wd);
    end
    check("m0_wr_ready", m0_wr_ready, hs && win == 0);
    check("m1_wr_ready", m1_wr_ready, hs && win == 1);

    rdAny = m0_rd_valid || m1_rd_valid;
    sel = (m0_rd_valid && m1_rd_valid) ? rdFav : (m1_rd_valid ? 1 : 0);
    ra = (sel == 1) ? m1_rd_addr : m0_rd_addr;
    hazard = wrAny && (wa == ra);
    issue = !busy && rdAny && !hazard;
    check("mem_rdready", mem_rdready, issue);
    check("m0_rd_ready", m0_rd_ready, issue && sel == 0);
    check("m1_rd_ready", m1_rd_ready, issue && sel == 1);
    if (issue) check("mem_rdaddr", mem_rdaddr, ra);

    accW0 = hs && win == 0;
    accW1 = hs && win == 1;
    accR0 = issue && sel == 0;
    accR1 = issue && sel == 1;
    if (issue) begin
      owner = sel;
      rdFav = 1 - sel;
      busy = 1;
      pendErr = memSilent;
      pendData = memSilent ? '0 : shadow[ra];
      respAt = cyc + (memSilent ? TMO_CYCLES + 1 : 2);
    end
    if (hs) begin
      shadow[wa] = wd;
      wrFav = 1 - win;
    end
  endtask

  task automatic runCycle(input bit rst,
                          input bit w0v, input logic [ADDRW-1:0] w0a, input logic [DATAW-1:0] w0d,
                          input bit w1v, input logic [ADDRW-1:0] w1a, input logic [DATAW-1:0] w1d,
                          input bit r0v, input logic [ADDRW-1:0] r0a,
                          input bit r1v, input logic [ADDRW-1:0] r1a);
    applyStimulus(rst, w0v, w0a, w0d, w1v, w1a, w1d, r0v, r0a, r1v, r1a);
    #1;
    checkOutput();
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Watchdog so the bench always ends even if something stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios, then random traffic with held requests.
  initial begin
    bit w0v, w1v, r0v, r1v, rst;
    logic [ADDRW-1:0] w0a, w1a, r0a, r1a;
    logic [DATAW-1:0] w0d, w1d;
    int k;
    for (int i = 0; i < 16; i++) begin
      memArray[i] = '0;
      shadow[i] = '0;
    end
    lastData[0] = '0;
    lastData[1] = '0;
    mem_wrready = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Reset, write 0xDEADBEEF to addr 3 from m0 and read it back.
    for (int i = 0; i < 3; i++) runCycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    runCycle(0, 1, 4'd3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    runCycle(0, 0, 0, 0, 0, 0, 0, 1, 4'd3, 0, 0);
    idle(3);
    check("t1_rsp_data", m0_rsp_data, 32'hDEADBEEF);

    // Fresh reset, then both requesters write for 4 cycles; m0 wins first.
    runCycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) runCycle(0, 1, 4'd1, 32'hA0A0_0001, 1, 4'd2, 32'hB0B0_0002, 0, 0, 0, 0);
    runCycle(0, 0, 0, 0, 0, 0, 0, 1, 4'd1, 1, 4'd2);
    idle(1);
    runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd2);
    idle(3);
    check("t2_m0_data", m0_rsp_data, 32'hA0A0_0001);
    check("t2_m1_data", m1_rsp_data, 32'hB0B0_0002);

    // Read of addr 5 collides with a write to addr 5 and must stall a cycle.
    runCycle(0, 0, 0, 0, 1, 4'd5, 32'h1234, 1, 4'd5, 0, 0);
    runCycle(0, 0, 0, 0, 0, 0, 0, 1, 4'd5, 0, 0);
    idle(3);
    check("t3_rsp_data", m0_rsp_data, 32'h1234);

    // Silent memory: m1 read of addr 7 times out.
    memSilent = 1'b1;
    runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd7);
    k = 1;
    while (!m1_rsp_valid && k < 40) begin
      idle(1);
      k++;
    end
    check("t4_latency", k, TMO_CYCLES + 1);
    check("t4_err", m1_rsp_err, 1'b1);
    check("t4_data", m1_rsp_data, '0);
    memSilent = 1'b0;
    runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd3);
    idle(3);

    // Both requesters hold rd_valid continuously.
    for (int i = 0; i < 10; i++) runCycle(0, 0, 0, 0, 0, 0, 0, 1, 4'd1, 1, 4'd2);
    idle(3);

    // Reset the cycle after a read is accepted, then read again.
    runCycle(0, 0, 0, 0, 0, 0, 0, 1, 4'd2, 0, 0);
    runCycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd5);
    idle(3);

    // Stray rdvalid while idle must be ignored.
    spurious = 1'b1;
    idle(1);
    spurious = 1'b0;
    idle(2);

    // Random traffic; a request stays put until the model says it was taken.
    {w0v, w1v, r0v, r1v} = 4'b0000;
    {w0a, w1a, r0a, r1a} = '0;
    w0d = '0;
    w1d = '0;
    {accW0, accW1, accR0, accR1} = 4'b1111;
    for (int i = 0; i < 4000; i++) begin
      if (!w0v || accW0) begin w0v = $urandom_range(0, 1); w0a = ADDRW'($urandom_range(0, 7)); w0d = $urandom; end
      if (!w1v || accW1) begin w1v = $urandom_range(0, 1); w1a = ADDRW'($urandom_range(0, 7)); w1d = $urandom; end
      if (!r0v || accR0) begin r0v = $urandom_range(0, 1); r0a = ADDRW'($urandom_range(0, 7)); end
      if (!r1v || accR1) begin r1v = $urandom_range(0, 1); r1a = ADDRW'($urandom_range(0, 7)); end
      mem_wrready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 149) == 0) memSilent = !memSilent;
      spurious = (!busy || cyc >= respAt) && ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 249) == 0);
      if (rst) {w0v, w1v, r0v, r1v} = 4'b0000;
      runCycle(rst, w0v, w0a, w0d, w1v, w1a, w1d, r0v, r0a, r1v, r1a);
    end
    spurious = 1'b0;
    memSilent = 1'b0;
    mem_wrready = 1'b1;
    idle(TMO_CYCLES + 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
